division_operand_negate: RTL and testbench
==========================================

# division_operand_negate

Parametrised operand-conditioning stage for the signed divider datapath. It accepts a dividend/divisor pair on a start pulse and records the operand signs. It converts each negative operand to its magnitude with a chunked, multi-cycle two's-complement (invert + 1) carry chain, then presents both magnitudes with quotient/remainder sign flags and a done pulse to the downstream unsigned divider core.

## Interface
- WIDTH, 8, operand width in bits; must be at least 2.
- CHUNK, 4, bits negated per clock; WIDTH must be an integer multiple of CHUNK.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled in IDLE or DONE only
- mode_signed  input  1  1 = treat operands as two's complement; 0 = unsigned pass-through
- first_nr_in  input  WIDTH  dividend
- second_nr_in  input  WIDTH  divisor
- busy  output  1  high while in NEG state
- done  output  1  one-cycle pulse; outputs valid while high and held afterwards
- first_mag  output  WIDTH  dividend magnitude (unsigned)
- second_mag  output  WIDTH  divisor magnitude (unsigned)
- quot_neg  output  1  quotient must be negated downstream
- rem_neg  output  1  remainder must be negated downstream
- div_zero  output  1  divisor was zero (see Configuration)

## Operation
- States:
  - IDLE: reset state.
  - NEG: K = WIDTH/CHUNK cycles.
  - DONE: one cycle, then IDLE.
- Start acceptance: start in IDLE or DONE latches both operands and mode_signed.
- Signed flags: s1 = first_nr_in[WIDTH-1] & mode_signed; s2 likewise for the divisor.
- Flag outputs: quot_neg = s1 ^ s2 and rem_neg = s1, both registered at start. In unsigned mode both are 0.
- mode_signed=1 -> NEG with chunk index 0 and carry = 1 for each operand.
- mode_signed=0 -> DONE directly; magnitudes = operands unchanged.
- NEG, per cycle, per operand:
  - If its sign is set: chunk = ~chunk + carry, and carry-out is kept for the next chunk.
  - Otherwise the chunk passes through unchanged.
  - The index increments each cycle; after chunk K-1 the state goes to DONE.
- Most-negative operand: 2^(WIDTH-1) negates to the same bit pattern, which is the correct unsigned magnitude. No error flag is raised.
- start while busy is ignored; no queueing.
- Magnitudes and flags hold their last values from DONE until the next accepted start. At that start they update to the new latched values.

## Timing
- Reset values (asynchronous): state IDLE; busy = 0, done = 0, first_mag = 0, second_mag = 0, quot_neg = 0, rem_neg = 0, div_zero = 0; chunk index = 0.
- Signed latency: start sampled at edge E0; chunk j is processed at edge E(j+1); done is high during the cycle after E(K). Start-to-done is K+1 cycles (3 for the default configuration).
- Unsigned or zero-skip latency: done is high during the cycle after E0 (1 cycle).
- busy is high exactly the K cycles in NEG. busy and done are never high together.
- Back-to-back: a start during the DONE cycle is accepted, so throughput is one result per K+1 cycles signed.
- Reset mid-NEG aborts the operation immediately: all outputs return to reset values and no done pulse is issued.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - At start, div_zero is registered as (second_nr_in == 0).
  - A zero divisor skips NEG and goes straight to DONE with first_mag = 0, second_mag = 0, quot_neg = 0 and rem_neg = 0.
- DIV_ZERO_DETECT_EN undefined:
  - div_zero is tied to 0.
  - A zero divisor is processed like any other operand (it passes through as 0).

## Test plan
- WIDTH=8, CHUNK=4, signed, 0xFA / 0x03 -> busy 2 cycles, then done; first_mag = 0x06, second_mag = 0x03, quot_neg = 1, rem_neg = 1.
- Signed 0x80 / 0xFF -> first_mag = 0x80, second_mag = 0x01, quot_neg = 0, rem_neg = 1; done 3 cycles after start.
- Unsigned 0xFA / 0x03 -> done the cycle after start; first_mag = 0xFA, second_mag = 0x03, quot_neg = 0, rem_neg = 0, busy never high.
- Signed 0x07 / 0x00:
  - With DIV_ZERO_DETECT_EN: div_zero = 1, magnitudes = 0, done after 1 cycle.
  - Without it: div_zero = 0, first_mag = 0x07, second_mag = 0x00, done after 3 cycles.
- Start 0xF0 / 0x02, then a second start with 0x11 / 0x11 during NEG -> the second start is ignored; result is first_mag = 0x10, second_mag = 0x02. A start in the DONE cycle is accepted.
- Signed start, rst pulsed in the 2nd NEG cycle -> all outputs 0 immediately, no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/division_operand_negate.sv
// division_operand_negate: signed-divider operand conditioning (sign capture plus chunked two's-complement negation); define DIV_ZERO_DETECT_EN to enable zero-divisor detection and skip.
module division_operand_negate #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] first_nr_in,
    input  logic [WIDTH-1:0] second_nr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] first_mag,
    output logic [WIDTH-1:0] second_mag,
    output logic             quot_neg,
    output logic             rem_neg,
    output logic             div_zero
);
    localparam int K  = WIDTH / CHUNK;
    localparam int IW = K > 1 ? $clog2(K) : 1;
    typedef enum logic [1:0] {IDLE, NEG, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] fm_q, fm_d, sm_q, sm_d;
    logic c1_q, c1_d, c2_q, c2_d, qn_q, qn_d, rn_q, rn_d, dz_q, dz_d;
    logic s1, s2, s2_q, zero;
    logic [CHUNK-1:0] ch1, ch2;
    logic [CHUNK:0] sum1, sum2;
    assign s1 = first_nr_in[WIDTH-1] & mode_signed;
    assign s2 = second_nr_in[WIDTH-1] & mode_signed;
`ifdef DIV_ZERO_DETECT_EN
    assign zero = (second_nr_in == '0);
`else
    assign zero = 1'b0;
`endif
    // The registered flags already encode the operand signs: rem_neg = s1, quot_neg ^ rem_neg = s2.
    assign s2_q = qn_q ^ rn_q;
    assign ch1  = fm_q[idx_q*CHUNK +: CHUNK];
    assign ch2  = sm_q[idx_q*CHUNK +: CHUNK];
    assign sum1 = {1'b0, ~ch1} + {{CHUNK{1'b0}}, c1_q};
    assign sum2 = {1'b0, ~ch2} + {{CHUNK{1'b0}}, c2_q};
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fm_d    = fm_q;
        sm_d    = sm_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        qn_d    = qn_q;
        rn_d    = rn_q;
        dz_d    = dz_q;
        if (start && state_q != NEG) begin
            fm_d    = zero ? '0 : first_nr_in;
            sm_d    = zero ? '0 : second_nr_in;
            qn_d    = ~zero & (s1 ^ s2);
            rn_d    = ~zero & s1;
            dz_d    = zero;
            c1_d    = 1'b1;
            c2_d    = 1'b1;
            idx_d   = '0;
            state_d = (mode_signed && !zero) ? NEG : DONE;
        end else if (state_q == NEG) begin
            fm_d[idx_q*CHUNK +: CHUNK] = rn_q ? sum1[CHUNK-1:0] : ch1;
            sm_d[idx_q*CHUNK +: CHUNK] = s2_q ? sum2[CHUNK-1:0] : ch2;
            c1_d    = sum1[CHUNK];
            c2_d    = sum2[CHUNK];
            idx_d   = (idx_q == IW'(K-1)) ? '0 : idx_q + 1'b1;
            state_d = (idx_q == IW'(K-1)) ? DONE : NEG;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fm_q    <= '0;
            sm_q    <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            qn_q    <= 1'b0;
            rn_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fm_q    <= fm_d;
            sm_q    <= sm_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            qn_q    <= qn_d;
            rn_q    <= rn_d;
            dz_q    <= dz_d;
        end
    end
    assign busy       = (state_q == NEG);
    assign done       = (state_q == DONE);
    assign first_mag  = fm_q;
    assign second_mag = sm_q;
    assign quot_neg   = qn_q;
    assign rem_neg    = rn_q;
    assign div_zero   = dz_q;
endmodule

// File: tb/tb_division_operand_negate.sv
// tb_division_operand_negate: randomized and directed checks of division_operand_negate against an arithmetic model.
module tb_division_operand_negate;
    localparam int W = 8;
    localparam int C = 4;
    localparam int K = W / C;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode_signed = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic busy, done, quot_neg, rem_neg, div_zero;
    logic [W-1:0] first_mag, second_mag;
    int vectors = 0, errors = 0;

    division_operand_negate #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_signed(mode_signed),
        .first_nr_in(a_in), .second_nr_in(b_in), .busy(busy), .done(done),
        .first_mag(first_mag), .second_mag(second_mag), .quot_neg(quot_neg),
        .rem_neg(rem_neg), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, b, input logic m,
                                  output logic [W-1:0] fm, sm, output logic qn, rn, dz);
        logic s1, s2;
        s1 = m & a[W-1];
        s2 = m & b[W-1];
        fm = s1 ? W'(0 - int'(a)) : a;
        sm = s2 ? W'(0 - int'(b)) : b;
        dz = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 0) begin
            fm = '0; sm = '0; s1 = 1'b0; s2 = 1'b0; dz = 1'b1;
        end
`endif
        qn = s1 ^ s2;
        rn = s1;
    endfunction

    // Drives one start and waits for done; entered and left at #1 after a rising edge.
    task automatic run_op(input logic [W-1:0] a, b, input logic m);
        logic [W-1:0] efm, esm;
        logic eqn, ern, edz;
        int lat, bcnt, elat;
        model(a, b, m, efm, esm, eqn, ern, edz);
        elat = (m && !edz) ? K + 1 : 1;
        a_in = a; b_in = b; mode_signed = m; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1 lat++;
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL timeout a=%h b=%h m=%0d: done never rose", a, b, m); end
        vectors++; if (lat !== elat) begin errors++; $display("FAIL latency a=%h b=%h m=%0d: got %0d want %0d", a, b, m, lat, elat); end
        vectors++; if (bcnt !== elat - 1) begin errors++; $display("FAIL busy_cycles a=%h b=%h m=%0d: got %0d want %0d", a, b, m, bcnt, elat - 1); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_with_done a=%h b=%h m=%0d: got %b want 0", a, b, m, busy); end
        vectors++; if (first_mag !== efm) begin errors++; $display("FAIL first_mag a=%h b=%h m=%0d: got %h want %h", a, b, m, first_mag, efm); end
        vectors++; if (second_mag !== esm) begin errors++; $display("FAIL second_mag a=%h b=%h m=%0d: got %h want %h", a, b, m, second_mag, esm); end
        vectors++; if (quot_neg !== eqn) begin errors++; $display("FAIL quot_neg a=%h b=%h m=%0d: got %b want %b", a, b, m, quot_neg, eqn); end
        vectors++; if (rem_neg !== ern) begin errors++; $display("FAIL rem_neg a=%h b=%h m=%0d: got %b want %b", a, b, m, rem_neg, ern); end
        vectors++; if (div_zero !== edz) begin errors++; $display("FAIL div_zero a=%h b=%h m=%0d: got %b want %b", a, b, m, div_zero, edz); end
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        vectors++; if (first_mag !== '0) begin errors++; $display("FAIL %s first_mag: got %h want 00", tag, first_mag); end
        vectors++; if (second_mag !== '0) begin errors++; $display("FAIL %s second_mag: got %h want 00", tag, second_mag); end
        vectors++; if ({quot_neg, rem_neg, div_zero} !== 3'b000) begin errors++; $display("FAIL %s flags: got %b want 000", tag, {quot_neg, rem_neg, div_zero}); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_plan_vectors();
        run_op(8'hFA, 8'h03, 1'b1); @(posedge clk); #1;
        run_op(8'h80, 8'hFF, 1'b1); @(posedge clk); #1;
        run_op(8'hFA, 8'h03, 1'b0); @(posedge clk); #1;
        run_op(8'h07, 8'h00, 1'b1); @(posedge clk); #1;
        run_op(8'h80, 8'h80, 1'b1); @(posedge clk); #1;
        run_op(8'h00, 8'h00, 1'b0); @(posedge clk); #1;
    endtask

    task automatic test_hold();
        logic [W-1:0] efm, esm;
        logic eqn, ern, edz;
        run_op(8'h9C, 8'h85, 1'b1);
        model(8'h9C, 8'h85, 1'b1, efm, esm, eqn, ern, edz);
        repeat (3) begin
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", done); end
            vectors++; if ({first_mag, second_mag, quot_neg, rem_neg} !== {efm, esm, eqn, ern}) begin
                errors++; $display("FAIL hold_outputs: got %h %h %b %b want %h %h %b %b", first_mag, second_mag, quot_neg, rem_neg, efm, esm, eqn, ern);
            end
        end
    endtask

    task automatic test_ignore_busy_start();
        a_in = 8'hF0; b_in = 8'h02; mode_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1 a_in = 8'h11; b_in = 8'h11;
        @(posedge clk); @(posedge clk); #1 start = 1'b0;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
        vectors++; if (first_mag !== 8'h10) begin errors++; $display("FAIL ignore_first_mag: got %h want 10", first_mag); end
        vectors++; if (second_mag !== 8'h02) begin errors++; $display("FAIL ignore_second_mag: got %h want 02", second_mag); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_back_to_back();
        run_op(8'hF0, 8'h02, 1'b1);
        run_op(8'h11, 8'hEE, 1'b1);
        run_op(8'h85, 8'h7F, 1'b0);
        run_op(8'hC3, 8'h81, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_neg();
        a_in = 8'hF0; b_in = 8'h92; mode_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midneg_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1 check_zero_outputs("midneg_reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midneg_no_done: got %b want 0", done); end
            @(posedge clk); #1;
        end
        run_op(8'hF0, 8'h92, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 80; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'h80;
            run_op(a, b, 1'($urandom_range(0, 3) != 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_hold();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid_neg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
